mlp_load_sequencer: RTL and testbench
=====================================

Name: mlp_load_sequencer

Overview:
- Controller that sits between a word-stream source (DMA or bench driver) and MLP_acc_top.
- Turns a flat stream of 32-bit words into the accelerator's load sequence: layer 0 inputs interleaved with weights, then weight-only passes for layers 1..7.
- After loading, it waits a drain period, then collects the 128 result words into an output stream with last/done/error signalling.

Parameters:
- NUM_LAYERS, 8, layers computed; layer index width 3.
- ROWS, 16, rows per layer; row index width 4.
- BEATS, 8, 32-bit words per row (2 x 16-bit elements each).
- DRAIN_CYCLES, 4, idle cycles between the last load word and the start of result collection.
- RESULT_WORDS, 128, result words expected (16x16 x 16-bit / 2).
- TIMEOUT, 1024, maximum cycles between result words in READ before error.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- start_i  in  1  pulse; begins a run when idle
- busy_o  out  1  high from the cycle after an accepted start until done_o or error
- done_o  out  1  one-cycle pulse when the run completes
- err_o  out  1  sticky error flag; cleared by an accepted start
- in_valid_i  in  1  source word valid
- in_data_i  in  32  source word
- in_ready_o  out  1  sequencer accepts a word
- acc_load_en_o  out  1  word qualifier to the accelerator
- acc_load_payload_o  out  32  word to the accelerator
- acc_load_type_o  out  1  1 = input row, 0 = weight
- acc_input_load_number_o  out  4  current row
- acc_layer_number_o  out  3  current layer
- acc_weight_number_o  out  3  weight beat within the row
- acc_result_valid_i  in  1  accelerator result valid
- acc_result_payload_i  in  32  accelerator result word
- res_valid_o  out  1  result word valid (no backpressure)
- res_data_o  out  32  result word
- res_last_o  out  1  marks the final result word

Behaviour:
- States: IDLE, LOAD_IN, LOAD_W, DRAIN, READ, DONE.
- Reset values: all outputs 0; state IDLE; layer, row, beat and drain counters 0. Reset mid-run aborts immediately to IDLE with no done_o.
- IDLE + start_i:
  - clears err_o and all counters;
  - next state is LOAD_IN.
  - start_i in any other state is ignored.
- Source handshake:
  - in_ready_o is high only in LOAD_IN and LOAD_W (combinational from state).
  - A transfer occurs when in_valid_i and in_ready_o are both high.
- Accelerator outputs:
  - all are registered; a transferred word appears on the acc_* outputs the following cycle with acc_load_en_o = 1, so latency is 1 cycle;
  - when no transfer occurs, acc_load_en_o = 0 next cycle (bubble) and payload/index outputs hold their values.
- Field values per word:
  - acc_load_type_o = 1 in LOAD_IN, 0 in LOAD_W;
  - acc_weight_number_o = beat in LOAD_W, 0 in LOAD_IN;
  - acc_input_load_number_o = row;
  - acc_layer_number_o = layer.
- Beat counter: increments on each transfer and wraps at BEATS-1.
- LOAD_IN transitions: on the transfer at beat 7, go to LOAD_W (same row).
- LOAD_W transitions on the transfer at beat 7:
  - row < 15: row++. If layer == 0, go to LOAD_IN; otherwise stay in LOAD_W.
  - row == 15, layer < 7: row = 0, layer++, stay in LOAD_W.
  - row == 15, layer == 7: go to DRAIN.
- Word count per run: 16 x 16 + 7 x 16 x 8 = 1152 words.
- DRAIN: count DRAIN_CYCLES cycles, then go to READ; the timeout counter is zeroed on entry to READ.
- READ, on each acc_result_valid_i:
  - register the word to res_data_o with res_valid_o = 1 the next cycle;
  - increment the result count and zero the timeout counter;
  - when the count reaches RESULT_WORDS, assert res_last_o on that word and go to DONE.
- DONE: done_o = 1 for exactly one cycle, busy_o drops the same cycle, then go to IDLE.
- Timeout: if TIMEOUT cycles pass in READ with no result word, set err_o, drop busy_o and go to IDLE; done_o is not pulsed.
- Spurious results: acc_result_valid_i seen in IDLE, LOAD_IN, LOAD_W or DRAIN sets err_o and is not forwarded; the run continues.
- Counter widths: result count 8 bits; timeout counter is clog2(TIMEOUT+1) bits and saturates.

Decomposition:
- Package mlp_seq_pkg holds:
  - the state enum typedef;
  - constants for layer, row and beat widths;
  - ACC_TYPE_INPUT = 1 and ACC_TYPE_WEIGHT = 0.
- One natural sub-module, mlp_seq_index_cnt: the nested beat/row/layer counter with a layer-0 input-phase flag and a last-word flag.
- The FSM, result capture and timeout stay in the top.

Test Plan:
- Reset, then start with in_valid_i held high and words 0..1151:
  - acc_load_en_o is high for 1152 consecutive cycles starting 2 cycles after start;
  - word 0 shows type 1, row 0, layer 0;
  - word 8 shows type 0, weight 0;
  - word 256 shows layer 1, row 0, type 0;
  - busy_o falls after done_o.
- Drop in_valid_i for 3 cycles at word 20 → exactly 3 acc_load_en_o = 0 bubbles; indices and payload hold; the sequence resumes with word 20's successor intact.
- In READ, drive 128 results 0x00010000 + n with gaps of 0..5 cycles:
  - res_data_o matches each word 1 cycle later;
  - res_last_o is high only on n = 127;
  - done_o pulses once.
- In READ, supply 10 results then none → err_o = 1 after 1024 idle cycles, no done_o, state IDLE; the next start clears err_o.
- Pulse acc_result_valid_i during LOAD_W → err_o = 1, res_valid_o stays 0, loading completes normally.
- Assert rst for 1 cycle at word 500 → all outputs 0 next cycle; a new start runs a full clean 1152-word sequence.

Source files
------------

// File: rtl/mlp_seq_pkg.sv
// Shared types and constants for the MLP load sequencer.
//   state_t          : sequencer FSM states
//   *_W              : index / counter widths
//   ACC_TYPE_*       : encoding of acc_load_type_o
package mlp_seq_pkg;

    localparam int DATA_W       = 32;
    localparam int NUM_LAYERS   = 8;
    localparam int ROWS         = 16;
    localparam int BEATS        = 8;
    localparam int DRAIN_CYCLES = 4;
    localparam int RESULT_WORDS = 128;
    localparam int TIMEOUT      = 1024;

    localparam int LAYER_W   = 3;
    localparam int ROW_W     = 4;
    localparam int BEAT_W    = 3;
    localparam int DRAIN_W   = $clog2(DRAIN_CYCLES + 1);
    localparam int RES_CNT_W = 8;
    localparam int TMO_W     = $clog2(TIMEOUT + 1);

    localparam logic ACC_TYPE_INPUT  = 1'b1;
    localparam logic ACC_TYPE_WEIGHT = 1'b0;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        LOAD_IN = 3'd1,
        LOAD_W  = 3'd2,
        DRAIN   = 3'd3,
        READ    = 3'd4,
        DONE    = 3'd5
    } state_t;

endpackage

// File: rtl/mlp_load_sequencer_if.sv
// Bundles the three data paths around the sequencer:
//   source stream  : in_valid_i / in_data_i / in_ready_o
//   accelerator    : acc_load_* / acc_*_number_o (to MLP_acc_top),
//                    acc_result_valid_i / acc_result_payload_i (from it)
//   result stream  : res_valid_o / res_data_o / res_last_o
// master: the sequencer side.  slave: source, accelerator and result sink.
interface mlp_load_sequencer_if;
    import mlp_seq_pkg::*;

    logic                in_valid_i;
    logic [DATA_W-1:0]   in_data_i;
    logic                in_ready_o;

    logic                acc_load_en_o;
    logic [DATA_W-1:0]   acc_load_payload_o;
    logic                acc_load_type_o;
    logic [ROW_W-1:0]    acc_input_load_number_o;
    logic [LAYER_W-1:0]  acc_layer_number_o;
    logic [BEAT_W-1:0]   acc_weight_number_o;

    logic                acc_result_valid_i;
    logic [DATA_W-1:0]   acc_result_payload_i;

    logic                res_valid_o;
    logic [DATA_W-1:0]   res_data_o;
    logic                res_last_o;

    modport master (
        input  in_valid_i, in_data_i, acc_result_valid_i, acc_result_payload_i,
        output in_ready_o,
        output acc_load_en_o, acc_load_payload_o, acc_load_type_o,
        output acc_input_load_number_o, acc_layer_number_o, acc_weight_number_o,
        output res_valid_o, res_data_o, res_last_o
    );

    modport slave (
        output in_valid_i, in_data_i, acc_result_valid_i, acc_result_payload_i,
        input  in_ready_o,
        input  acc_load_en_o, acc_load_payload_o, acc_load_type_o,
        input  acc_input_load_number_o, acc_layer_number_o, acc_weight_number_o,
        input  res_valid_o, res_data_o, res_last_o
    );

endinterface

// File: rtl/mlp_seq_index_cnt.sv
// Nested beat / row / layer counter for the load sequence.
// Layer 0 rows are loaded twice (input pass then weight pass); the
// input_phase flag tracks which pass the current row is in.
//   clk, rst       : clock, synchronous active-high reset
//   clear          : start of run (indices 0, input pass)
//   advance        : one word transferred
//   beat/row/layer : current indices
//   input_phase    : current word belongs to a layer-0 input pass
//   row_end        : current word is the last beat of its pass
//   next_is_input  : finishing this pass starts a new layer-0 input pass
//   last_word      : current word is the final word of the run
module mlp_seq_index_cnt
    import mlp_seq_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic               clear,
    input  logic               advance,
    output logic [BEAT_W-1:0]  beat,
    output logic [ROW_W-1:0]   row,
    output logic [LAYER_W-1:0] layer,
    output logic               input_phase,
    output logic               row_end,
    output logic               next_is_input,
    output logic               last_word
);

    localparam logic [BEAT_W-1:0]  BEAT_MAX  = BEAT_W'(BEATS - 1);
    localparam logic [ROW_W-1:0]   ROW_MAX   = ROW_W'(ROWS - 1);
    localparam logic [LAYER_W-1:0] LAYER_MAX = LAYER_W'(NUM_LAYERS - 1);

    assign row_end       = (beat == BEAT_MAX);
    assign next_is_input = row_end && !input_phase && (layer == '0) && (row != ROW_MAX);
    assign last_word     = row_end && !input_phase && (row == ROW_MAX) && (layer == LAYER_MAX);

    // NOTE: state registers use non-blocking assignments so every flop
    // samples the pre-edge values of its neighbours, matching hardware.
    always_ff @(posedge clk) begin
        if (rst) begin
            beat        <= '0;
            row         <= '0;
            layer       <= '0;
            input_phase <= 1'b0;
        end else if (clear) begin
            beat        <= '0;
            row         <= '0;
            layer       <= '0;
            input_phase <= 1'b1;
        end else if (advance) begin
            if (!row_end) begin
                beat <= beat + 1'b1;
            end else begin
                beat <= '0;
                if (input_phase) begin
                    // Input pass done: the weight pass reuses the same row.
                    input_phase <= 1'b0;
                end else if (row != ROW_MAX) begin
                    row         <= row + 1'b1;
                    input_phase <= (layer == '0);
                end else begin
                    row <= '0;
                    if (layer != LAYER_MAX) begin
                        layer <= layer + 1'b1;
                    end
                end
            end
        end
    end

endmodule

// File: rtl/mlp_load_sequencer.sv
// Converts a flat 32-bit word stream into the MLP accelerator load
// sequence, waits for the pipeline to drain, then forwards the result
// words to an output stream.
//   clk, rst  : clock, synchronous active-high reset
//   start_i   : begins a run when idle
//   busy_o    : run in progress
//   done_o    : one-cycle pulse at successful completion
//   err_o     : sticky error (timeout or unexpected result word)
//   bus       : source stream, accelerator load/result, result stream
module mlp_load_sequencer
    import mlp_seq_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start_i,
    output logic                 busy_o,
    output logic                 done_o,
    output logic                 err_o,
    mlp_load_sequencer_if.master bus
);

    state_t state_q, state_d;

    logic [BEAT_W-1:0]  beat;
    logic [ROW_W-1:0]   row;
    logic [LAYER_W-1:0] layer;
    logic               input_phase;
    logic               row_end;
    logic               next_is_input;
    logic               last_word;

    logic in_ready;
    logic xfer;
    logic start_ok;
    logic spurious;
    logic res_take;
    logic res_final;
    logic timeout_hit;
    logic drain_end;

    logic [DRAIN_W-1:0]   drain_q;
    logic [RES_CNT_W-1:0] res_cnt_q;
    logic [TMO_W-1:0]     tmo_q;
    logic                 err_q;

    logic                acc_en_q;
    logic [DATA_W-1:0]   acc_payload_q;
    logic                acc_type_q;
    logic [ROW_W-1:0]    acc_row_q;
    logic [LAYER_W-1:0]  acc_layer_q;
    logic [BEAT_W-1:0]   acc_wnum_q;

    logic                res_valid_q;
    logic [DATA_W-1:0]   res_data_q;
    logic                res_last_q;

    mlp_seq_index_cnt u_index_cnt (
        .clk           (clk),
        .rst           (rst),
        .clear         (start_ok),
        .advance       (xfer),
        .beat          (beat),
        .row           (row),
        .layer         (layer),
        .input_phase   (input_phase),
        .row_end       (row_end),
        .next_is_input (next_is_input),
        .last_word     (last_word)
    );

    assign in_ready    = (state_q == LOAD_IN) || (state_q == LOAD_W);
    assign xfer        = bus.in_valid_i && in_ready;
    assign start_ok    = (state_q == IDLE) && start_i;
    assign spurious    = bus.acc_result_valid_i &&
                         (state_q inside {IDLE, LOAD_IN, LOAD_W, DRAIN});
    assign res_take    = (state_q == READ) && bus.acc_result_valid_i;
    assign res_final   = res_take && (res_cnt_q == RES_CNT_W'(RESULT_WORDS - 1));
    assign timeout_hit = (state_q == READ) && !bus.acc_result_valid_i &&
                         (tmo_q == TMO_W'(TIMEOUT - 1));
    assign drain_end   = (state_q == DRAIN) && (drain_q == DRAIN_W'(DRAIN_CYCLES - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // NOTE: state_d is given its default before the case so every path
    // assigns it and no latch is inferred.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (start_i) state_d = LOAD_IN;
            LOAD_IN: if (xfer && row_end) state_d = LOAD_W;
            LOAD_W: begin
                if (xfer && row_end) begin
                    if (last_word) begin
                        state_d = DRAIN;
                    end else if (next_is_input) begin
                        state_d = LOAD_IN;
                    end
                end
            end
            DRAIN:   if (drain_end) state_d = READ;
            READ: begin
                if (res_final) begin
                    state_d = DONE;
                end else if (timeout_hit) begin
                    state_d = IDLE;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        // NOTE: the payload and data registers are reset as well because
        // every output must read zero straight after reset.
        if (rst) begin
            acc_en_q      <= 1'b0;
            acc_payload_q <= '0;
            acc_type_q    <= 1'b0;
            acc_row_q     <= '0;
            acc_layer_q   <= '0;
            acc_wnum_q    <= '0;
            res_valid_q   <= 1'b0;
            res_data_q    <= '0;
            res_last_q    <= 1'b0;
            drain_q       <= '0;
            res_cnt_q     <= '0;
            tmo_q         <= '0;
            err_q         <= 1'b0;
        end else begin
            // Load path: one registered stage; indices hold on bubbles.
            acc_en_q <= xfer;
            if (xfer) begin
                acc_payload_q <= bus.in_data_i;
                acc_type_q    <= input_phase ? ACC_TYPE_INPUT : ACC_TYPE_WEIGHT;
                acc_row_q     <= row;
                acc_layer_q   <= layer;
                acc_wnum_q    <= input_phase ? '0 : beat;
            end

            res_valid_q <= res_take;
            res_last_q  <= res_final;
            if (res_take) begin
                res_data_q <= bus.acc_result_payload_i;
            end

            if (start_ok) begin
                err_q     <= 1'b0;
                drain_q   <= '0;
                res_cnt_q <= '0;
                tmo_q     <= '0;
            end

            if (state_q == DRAIN) begin
                drain_q <= drain_end ? '0 : drain_q + 1'b1;
                tmo_q   <= '0;
            end

            if (state_q == READ) begin
                if (res_take) begin
                    res_cnt_q <= res_cnt_q + 1'b1;
                    tmo_q     <= '0;
                end else if (tmo_q != TMO_W'(TIMEOUT)) begin
                    tmo_q <= tmo_q + 1'b1;
                end
            end

            // Placed after the start clear so an error in the start cycle wins.
            if (spurious || timeout_hit) begin
                err_q <= 1'b1;
            end
        end
    end

    assign busy_o = state_q inside {LOAD_IN, LOAD_W, DRAIN, READ};
    assign done_o = (state_q == DONE);
    assign err_o  = err_q;

    assign bus.in_ready_o              = in_ready;
    assign bus.acc_load_en_o           = acc_en_q;
    assign bus.acc_load_payload_o      = acc_payload_q;
    assign bus.acc_load_type_o         = acc_type_q;
    assign bus.acc_input_load_number_o = acc_row_q;
    assign bus.acc_layer_number_o      = acc_layer_q;
    assign bus.acc_weight_number_o     = acc_wnum_q;
    assign bus.res_valid_o             = res_valid_q;
    assign bus.res_data_o              = res_data_q;
    assign bus.res_last_o              = res_last_q;

endmodule

// File: tb/tb_mlp_load_sequencer.sv
// Directed bench for mlp_load_sequencer: load sequence, bubbles, result
// collection, timeout, unexpected results and mid-run reset.
module tb_mlp_load_sequencer;
    import mlp_seq_pkg::*;

    localparam int TOTAL_WORDS = 1152;

    logic clk = 1'b0;
    logic rst;
    logic start_i;
    logic busy_o;
    logic done_o;
    logic err_o;

    int total = 0;
    int bad   = 0;

    mlp_load_sequencer_if bus ();

    mlp_load_sequencer dut (
        .clk     (clk),
        .rst     (rst),
        .start_i (start_i),
        .busy_o  (busy_o),
        .done_o  (done_o),
        .err_o   (err_o),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    // Expected {type, row, layer, weight_number} of word k of a run.
    function automatic logic [10:0] exp_fields(input int k);
        int         j;
        int         w;
        logic       typ;
        logic [3:0] r;
        logic [2:0] l;
        logic [2:0] b;
        if (k < 256) begin
            r   = 4'(k / 16);
            w   = k % 16;
            typ = (w < 8);
            b   = 3'(w % 8);
            l   = 3'd0;
        end else begin
            j   = k - 256;
            l   = 3'(1 + j / 128);
            r   = 4'((j % 128) / 8);
            b   = 3'(j % 8);
            typ = 1'b0;
        end
        return {typ, r, l, typ ? 3'd0 : b};
    endfunction

    // Pulses start and streams words 0..1151, checking every cycle.
    task automatic drive_load(input int gap_at, input int gap_len,
                              input int spur_at, input int abort_at);
        int          next_word = 0;
        int          gaps_left = gap_len;
        int          bubbles   = 0;
        int          first_cyc = -1;
        int          cyc       = 0;
        int          cur;
        bit          pending;
        bit          have_last = 0;
        bit          spurred   = 0;
        logic [31:0] last_pay  = '0;
        logic [10:0] last_f    = '0;
        logic [46:0] obs;
        logic [46:0] exp;

        bus.in_valid_i = 1'b1;
        bus.in_data_i  = '0;
        start_i        = 1'b1;
        step;
        start_i = 1'b0;
        total++;
        if ({busy_o, err_o, bus.in_ready_o, bus.acc_load_en_o} !== 4'b1010) begin
            bad++;
            $display("FAIL start_accept busy/err/ready/en got=%b exp=1010",
                     {busy_o, err_o, bus.in_ready_o, bus.acc_load_en_o});
        end

        while (next_word < TOTAL_WORDS && cyc < 2000) begin
            if (next_word == abort_at) begin
                bus.in_valid_i = 1'b0;
                rst = 1'b1;
                step;
                rst = 1'b0;
                total++;
                if ({bus.acc_load_en_o, bus.acc_load_payload_o, bus.acc_load_type_o,
                     bus.acc_input_load_number_o, bus.acc_layer_number_o,
                     bus.acc_weight_number_o, bus.res_valid_o, bus.res_data_o,
                     bus.res_last_o, busy_o, done_o, err_o, bus.in_ready_o} !== '0) begin
                    bad++;
                    $display("FAIL abort_reset outputs not zero: en=%b pay=%h busy=%b done=%b err=%b rdy=%b",
                             bus.acc_load_en_o, bus.acc_load_payload_o, busy_o, done_o,
                             err_o, bus.in_ready_o);
                end
                return;
            end

            bus.in_valid_i = !(next_word == gap_at && gaps_left > 0);
            if (!bus.in_valid_i) gaps_left--;
            bus.in_data_i            = 32'(next_word);
            bus.acc_result_valid_i   = (next_word == spur_at) && !spurred;
            bus.acc_result_payload_i = 32'hdead_beef;
            if (bus.acc_result_valid_i) spurred = 1'b1;
            pending = bus.in_valid_i && bus.in_ready_o;
            cur     = next_word;
            step;
            cyc++;
            bus.acc_result_valid_i = 1'b0;

            if (pending) begin
                next_word++;
                last_pay  = 32'(cur);
                last_f    = exp_fields(cur);
                have_last = 1'b1;
                if (first_cyc < 0) first_cyc = cyc;
            end else if (have_last) begin
                bubbles++;
            end

            if (have_last) begin
                obs = {bus.acc_load_en_o, bus.acc_load_payload_o, bus.acc_load_type_o,
                       bus.acc_input_load_number_o, bus.acc_layer_number_o,
                       bus.acc_weight_number_o, bus.res_valid_o, err_o, busy_o};
                exp = {pending, last_pay, last_f, 1'b0, spurred, 1'b1};
                total++;
                if (obs !== exp) begin
                    bad++;
                    $display("FAIL load_word idx=%0d got=%h exp=%h", cur, obs, exp);
                end
            end
        end
        bus.in_valid_i = 1'b0;

        total++;
        if (first_cyc != 1) begin
            bad++;
            $display("FAIL first_word_latency got=%0d exp=1", first_cyc);
        end
        total++;
        if (next_word != TOTAL_WORDS || bubbles != gap_len) begin
            bad++;
            $display("FAIL load_count words got=%0d exp=%0d bubbles got=%0d exp=%0d",
                     next_word, TOTAL_WORDS, bubbles, gap_len);
        end
        total++;
        if (bus.in_ready_o !== 1'b0) begin
            bad++;
            $display("FAIL ready_after_load got=%b exp=0", bus.in_ready_o);
        end
    endtask

    // Waits out the drain, feeds n_res results, then expects done or timeout.
    task automatic drive_results(input int n_res, input bit use_gaps,
                                 input bit expect_err, input bit expect_done);
        int          dones = 0;
        int          k;
        logic [31:0] w;
        logic        last_exp;

        for (int i = 0; i < DRAIN_CYCLES; i++) begin
            step;
            total++;
            if ({busy_o, bus.res_valid_o, bus.in_ready_o, done_o} !== 4'b1000) begin
                bad++;
                $display("FAIL drain cycle=%0d busy/rv/rdy/done got=%b exp=1000", i,
                         {busy_o, bus.res_valid_o, bus.in_ready_o, done_o});
            end
        end

        for (int n = 0; n < n_res; n++) begin
            w                        = 32'h0001_0000 + 32'(n);
            last_exp                 = (n == RESULT_WORDS - 1);
            bus.acc_result_valid_i   = 1'b1;
            bus.acc_result_payload_i = w;
            step;
            bus.acc_result_valid_i = 1'b0;
            if (done_o) dones++;
            total++;
            if ({bus.res_valid_o, bus.res_data_o, bus.res_last_o} !== {1'b1, w, last_exp}) begin
                bad++;
                $display("FAIL result n=%0d valid/data/last got=%b/%h/%b exp=1/%h/%b", n,
                         bus.res_valid_o, bus.res_data_o, bus.res_last_o, w, last_exp);
            end
            if (last_exp) begin
                total++;
                if ({done_o, busy_o} !== 2'b10) begin
                    bad++;
                    $display("FAIL done_cycle done/busy got=%b exp=10", {done_o, busy_o});
                end
            end
            if (use_gaps && n != n_res - 1) begin
                for (int g = 0; g < n % 6; g++) begin
                    step;
                    if (done_o) dones++;
                    total++;
                    if (bus.res_valid_o !== 1'b0) begin
                        bad++;
                        $display("FAIL result_gap n=%0d res_valid got=%b exp=0", n, bus.res_valid_o);
                    end
                end
            end
        end

        if (expect_done) begin
            for (int i = 0; i < 3; i++) begin
                step;
                if (done_o) dones++;
            end
            total++;
            if (dones != 1 || busy_o !== 1'b0 || err_o !== expect_err) begin
                bad++;
                $display("FAIL run_end dones=%0d busy=%b err=%b exp dones=1 busy=0 err=%b",
                         dones, busy_o, err_o, expect_err);
            end
        end else begin
            k = 0;
            while (k < 1100) begin
                step;
                k++;
                if (done_o) dones++;
                if (err_o === 1'b1) break;
            end
            total++;
            if (k != TIMEOUT || err_o !== 1'b1) begin
                bad++;
                $display("FAIL timeout_cycle got=%0d err=%b exp=%0d err=1", k, err_o, TIMEOUT);
            end
            total++;
            if (dones != 0 || {busy_o, done_o, bus.in_ready_o} !== 3'b000) begin
                bad++;
                $display("FAIL timeout_state dones=%0d busy/done/rdy=%b exp 0 and 000",
                         dones, {busy_o, done_o, bus.in_ready_o});
            end
        end
    endtask

    task automatic test_reset;
        rst = 1'b1;
        step;
        step;
        total++;
        if ({bus.acc_load_en_o, bus.acc_load_payload_o, bus.acc_load_type_o,
             bus.acc_input_load_number_o, bus.acc_layer_number_o, bus.acc_weight_number_o,
             bus.res_valid_o, bus.res_data_o, bus.res_last_o,
             busy_o, done_o, err_o, bus.in_ready_o} !== '0) begin
            bad++;
            $display("FAIL reset_outputs en=%b busy=%b done=%b err=%b rdy=%b",
                     bus.acc_load_en_o, busy_o, done_o, err_o, bus.in_ready_o);
        end
        rst = 1'b0;
        step;
        total++;
        if ({busy_o, bus.in_ready_o} !== 2'b00) begin
            bad++;
            $display("FAIL idle_after_reset busy/rdy got=%b exp=00", {busy_o, bus.in_ready_o});
        end
    endtask

    task automatic test_full_run;
        drive_load(-1, 0, -1, -1);
        drive_results(RESULT_WORDS, 1'b1, 1'b0, 1'b1);
    endtask

    task automatic test_bubble;
        drive_load(20, 3, -1, -1);
        drive_results(RESULT_WORDS, 1'b0, 1'b0, 1'b1);
    endtask

    task automatic test_timeout;
        drive_load(-1, 0, -1, -1);
        drive_results(10, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_spurious;
        drive_load(-1, 0, 300, -1);
        drive_results(RESULT_WORDS, 1'b0, 1'b1, 1'b1);
    endtask

    task automatic test_reset_abort;
        drive_load(-1, 0, -1, 500);
        drive_load(-1, 0, -1, -1);
        drive_results(RESULT_WORDS, 1'b0, 1'b0, 1'b1);
    endtask

    initial begin
        rst                      = 1'b1;
        start_i                  = 1'b0;
        bus.in_valid_i           = 1'b0;
        bus.in_data_i            = '0;
        bus.acc_result_valid_i   = 1'b0;
        bus.acc_result_payload_i = '0;

        test_reset;
        test_full_run;
        test_bubble;
        test_timeout;
        test_spurious;
        test_reset_abort;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
